// File: rtl/app_mul_pkg.sv
// Shared types and constants for the approximate-multiplier arbiter slice.
package app_mul_pkg;

  typedef logic [15:0] mul_operand_t;
  typedef logic [31:0] mul_product_t;

  // Pipeline latency of the shared Mitchell multiplier instance.
  localparam int MITCHELL_LATENCY = 2;

  // In-flight IDs are sized for the largest supported requester count (8).
  localparam int MAX_ID_W = 3;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } inflight_t;

endpackage

// File: rtl/app_mul_arbiter_rr.sv
// Combinational round-robin arbiter: first requester at or above the pointer wins, with wrap.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan N positions starting at the pointer and keep the first hit.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] j_idx;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    j_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      j_idx = IDX_W'(j);
      if (!any_o && req_i[j_idx]) begin
        any_o        = 1'b1;
        gnt_o[j_idx] = 1'b1;
        idx_o        = j_idx;
      end
    end
  end

endmodule

// File: rtl/app_mul_arbiter.sv
// Shares one fixed-latency multiplier among NUM_REQ requesters and routes each product back to its owner.
module app_mul_arbiter
  import app_mul_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = MITCHELL_LATENCY,
  parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  mul_operand_t [NUM_REQ-1:0] req_a,
  input  mul_operand_t [NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]         req_sign,
  output mul_operand_t               mul_a,
  output mul_operand_t               mul_b,
  output logic                       mul_sign,
  input  mul_product_t               mul_product,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [ID_W-1:0]            resp_id,
  output mul_product_t               resp_product,
  output logic                       idle,
  output logic [31:0]                ops_issued
);

  logic [NUM_REQ-1:0] gnt_raw;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  logic               grant_en;
  logic               hs;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  mul_operand_t       mul_a_q, mul_b_q;
  logic               mul_sign_q;
  logic [31:0]        ops_q;

  inflight_t          pipe_q [MUL_LATENCY+1];
  inflight_t          pipe_d [MUL_LATENCY+1];
  inflight_t          pipe_out;
  logic               busy;

  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]    resp_id_q, resp_id_d;
  mul_product_t       resp_product_q, resp_product_d;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt_raw),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Grants are suppressed while draining and while reset is held, so req_ready reads 0 in reset.
  assign grant_en  = enable & reset;
  assign req_ready = gnt_raw & {NUM_REQ{grant_en}};
  assign hs        = gnt_any & grant_en;

  assign pipe_out  = pipe_q[MUL_LATENCY];

  // Pointer advance and in-flight shift register next state.
  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
    pipe_d[0].valid = hs;
    pipe_d[0].id    = MAX_ID_W'(gnt_idx);
    for (int s = 1; s <= MUL_LATENCY; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end
  end

  // Response decode from the oldest pipeline stage; id and product hold between responses.
  always_comb begin
    resp_valid_d   = '0;
    resp_id_d      = resp_id_q;
    resp_product_d = resp_product_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid_d[i] = pipe_out.valid && (pipe_out.id == MAX_ID_W'(i));
    end
    if (pipe_out.valid) begin
      resp_id_d      = pipe_out.id[ID_W-1:0];
      resp_product_d = mul_product;
    end
  end

  // Any operation still travelling through the multiplier keeps the unit busy.
  always_comb begin
    busy = 1'b0;
    for (int s = 0; s <= MUL_LATENCY; s++) begin
      busy = busy | pipe_q[s].valid;
    end
  end

  // Operand capture, pointer and issue counter update on a handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_sign_q <= 1'b0;
      ops_q      <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (hs) begin
        mul_a_q    <= req_a[gnt_idx];
        mul_b_q    <= req_b[gnt_idx];
        mul_sign_q <= req_sign[gnt_idx];
        ops_q      <= ops_q + 32'd1;
      end
    end
  end

  // In-flight ID tracking; reset discards every outstanding operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s <= MUL_LATENCY; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s <= MUL_LATENCY; s++) begin
        pipe_q[s] <= pipe_d[s];
      end
    end
  end

  // Registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid_q   <= '0;
      resp_id_q      <= '0;
      resp_product_q <= '0;
    end else begin
      resp_valid_q   <= resp_valid_d;
      resp_id_q      <= resp_id_d;
      resp_product_q <= resp_product_d;
    end
  end

  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign mul_sign     = mul_sign_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_product = resp_product_q;
  assign ops_issued   = ops_q;
  assign idle         = ~busy & ~(|req_ready);

endmodule

// File: tb/tb_app_mul_arbiter.sv
// Scoreboard bench for app_mul_arbiter with a two-stage behavioural multiplier.
module tb_app_mul_arbiter;

  localparam int NUM_REQ = 4;
  localparam int LAT     = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [3:0]       req_valid, req_ready, req_sign, resp_valid;
  logic [3:0][15:0] req_a, req_b;
  logic [15:0]      mul_a, mul_b;
  logic             mul_sign;
  logic [31:0]      mul_product, resp_product, ops_issued;
  logic [1:0]       resp_id;
  logic             idle;

  always #5 clk = ~clk;

  app_mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sign(req_sign),
    .mul_a(mul_a), .mul_b(mul_b), .mul_sign(mul_sign), .mul_product(mul_product),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_product(resp_product),
    .idle(idle), .ops_issued(ops_issued)
  );

  // ---------------- multiplier model ----------------
  logic        use_mitchell;
  logic [31:0] p1, p2;

  function automatic logic [31:0] mitchell(logic [15:0] a, logic [15:0] b);
    int     k1, k2;
    longint f1, f2, sum, r;
    if (a == 0 || b == 0) return 32'd0;
    k1 = 0; k2 = 0;
    for (int i = 0; i < 16; i++) begin
      if (a[i]) k1 = i;
      if (b[i]) k2 = i;
    end
    f1  = (longint'(a) - (longint'(1) << k1)) << (16 - k1);
    f2  = (longint'(b) - (longint'(1) << k2)) << (16 - k2);
    sum = f1 + f2;
    if (sum < 65536) r = ((65536 + sum) << (k1 + k2)) >> 16;
    else             r = (sum << (k1 + k2 + 1)) >> 16;
    return r[31:0];
  endfunction

  function automatic logic [31:0] mul_model(logic [15:0] a, logic [15:0] b, logic s, logic mit);
    logic signed [31:0] sa, sb;
    if (mit) return mitchell(a, b);
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    if (s) return sa * sb;
    return {16'h0, a} * {16'h0, b};
  endfunction

  always @(posedge clk) begin
    p1 <= mul_model(mul_a, mul_b, mul_sign, use_mitchell);
    p2 <= p1;
  end
  assign mul_product = p2;

  // ---------------- bookkeeping ----------------
  typedef struct { logic [15:0] a; logic [15:0] b; logic s; logic [31:0] e; } op_t;
  typedef struct { int id; logic [31:0] prod; int cyc; } exp_t;

  op_t        opq [NUM_REQ][$];
  exp_t       sb[$];
  int         grant_log[$];
  logic [3:0] hs_vec;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         resp_count = 0;
  int         hs_total = 0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push_op(int r, logic [15:0] a, logic [15:0] b, logic s, logic [31:0] e);
    op_t o;
    o.a = a; o.b = b; o.s = s; o.e = e;
    opq[r].push_back(o);
  endtask

  // Requester agents: present the head of each queue, retire it once granted.
  initial begin
    op_t tmp;
    req_valid = '0; req_a = '0; req_b = '0; req_sign = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs_vec[i] && opq[i].size() > 0) tmp = opq[i].pop_front();
        if (opq[i].size() > 0) begin
          req_valid[i] = 1'b1;
          req_a[i]     = opq[i][0].a;
          req_b[i]     = opq[i][0].b;
          req_sign[i]  = opq[i][0].s;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Monitor and handshake observer, sampled on the falling edge.
  initial begin
    exp_t       e;
    logic [3:0] hs;
    hs_vec = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        sb.delete();
        resp_count = 0;
        hs_total   = 0;
        hs_vec     = '0;
      end else begin
        if (resp_valid != '0) begin
          resp_count++;
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_resp: got resp_valid=%b, expected no response (t=%0t)", resp_valid, $time);
          end else begin
            e = sb.pop_front();
            check("resp_id", 32'(resp_id), e.id);
            check("resp_onehot", 32'(resp_valid), 32'd1 << e.id);
            check("resp_product", resp_product, e.prod);
            check("resp_cycle", cyc, e.cyc);
          end
        end
        hs = req_valid & req_ready;
        if (req_ready != '0)
          check("ready_legal", 32'($onehot(req_ready) && ((req_ready & ~req_valid) == '0)), 32'd1);
        for (int i = 0; i < NUM_REQ; i++) begin
          if (hs[i] && opq[i].size() > 0) begin
            e.id   = i;
            e.prod = opq[i][0].e;
            e.cyc  = cyc + LAT + 2;
            sb.push_back(e);
            grant_log.push_back(i);
            hs_total++;
          end
        end
        hs_vec = hs;
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(string name);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      sync();
      if (opq[0].size() == 0 && opq[1].size() == 0 && opq[2].size() == 0 &&
          opq[3].size() == 0 && sb.size() == 0 && idle) done = 1'b1;
    end
    check({name, "_drain"}, 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) opq[i].delete();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  task automatic check_order(string name, int exp_ids[$]);
    check({name, "_count"}, grant_log.size(), exp_ids.size());
    for (int k = 0; k < exp_ids.size() && k < grant_log.size(); k++)
      check({name, "_grant"}, grant_log[k], exp_ids[k]);
  endtask

  task automatic check_reset_values(string name);
    check({name, "_ready"}, 32'(req_ready), 32'd0);
    check({name, "_mul_a"}, 32'(mul_a), 32'd0);
    check({name, "_mul_b"}, 32'(mul_b), 32'd0);
    check({name, "_mul_sign"}, 32'(mul_sign), 32'd0);
    check({name, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({name, "_resp_id"}, 32'(resp_id), 32'd0);
    check({name, "_resp_product"}, resp_product, 32'd0);
    check({name, "_ops"}, ops_issued, 32'd0);
    check({name, "_idle"}, 32'(idle), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    enable = 1'b1;
    use_mitchell = 1'b0;
    #12;
    check_reset_values("por");
    @(posedge clk);
    #3;
    reset = 1'b1;

    // Single request from requester 2.
    sync();
    push_op(2, 16'd3, 16'd5, 1'b0, 32'd15);
    sync();
    check("t1_ready", 32'(req_ready), 32'b0100);
    check("t1_busy", 32'(idle), 32'd0);
    wait_drain("t1");
    check("t1_ops", ops_issued, 32'd1);
    check("t1_idle", 32'(idle), 32'd1);
    check("t1_resp_count", resp_count, 1);

    // All four requesters continuously valid from reset.
    do_reset();
    sync();
    grant_log.delete();
    push_op(0, 16'd2,     16'd3,     1'b0, 32'd6);
    push_op(1, 16'd7,     16'd9,     1'b0, 32'd63);
    push_op(2, 16'd0,     16'd1234,  1'b0, 32'd0);
    push_op(3, 16'd5,     16'd5,     1'b0, 32'd25);
    push_op(0, 16'h0100,  16'h0100,  1'b0, 32'h0001_0000);
    push_op(1, 16'hFFFD,  16'd7,     1'b1, 32'hFFFF_FFEB);
    push_op(2, 16'd12,    16'd12,    1'b0, 32'd144);
    push_op(3, 16'hFFFF,  16'hFFFF,  1'b1, 32'd1);
    push_op(0, 16'hFFFF,  16'd2,     1'b0, 32'h0001_FFFE);
    push_op(1, 16'd1000,  16'd1000,  1'b0, 32'd1000000);
    push_op(2, 16'h8000,  16'h8000,  1'b1, 32'h4000_0000);
    push_op(3, 16'd255,   16'd255,   1'b0, 32'd65025);
    wait_drain("t2");
    check_order("t2", '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3});
    check("t2_ops", ops_issued, 32'd12);
    check("t2_resp_count", resp_count, 12);

    // Sparse round-robin with wrap: pointer moved to 3 first.
    sync();
    push_op(2, 16'd4, 16'd4, 1'b0, 32'd16);
    wait_drain("t3a");
    grant_log.delete();
    push_op(3, 16'd10, 16'd10, 1'b0, 32'd100);
    push_op(3, 16'd11, 16'd11, 1'b0, 32'd121);
    push_op(1, 16'd6,  16'd7,  1'b0, 32'd42);
    wait_drain("t3");
    check_order("t3", '{3, 1, 3});

    // Drain with enable low while three operations are in flight.
    sync();
    grant_log.delete();
    resp_count = 0;
    push_op(0, 16'd1,  16'd1,  1'b0, 32'd1);
    push_op(0, 16'd2,  16'd2,  1'b0, 32'd4);
    push_op(1, 16'd3,  16'd4,  1'b0, 32'd12);
    push_op(1, 16'd5,  16'd6,  1'b0, 32'd30);
    push_op(2, 16'd7,  16'd8,  1'b0, 32'd56);
    push_op(2, 16'd9,  16'd10, 1'b0, 32'd90);
    push_op(3, 16'd11, 16'd12, 1'b0, 32'd132);
    push_op(3, 16'd13, 16'd14, 1'b0, 32'd182);
    repeat (4) @(posedge clk);
    #2;
    enable = 1'b0;
    #1;
    check("t4_ready_off", 32'(req_ready), 32'd0);
    check("t4_busy", 32'(idle), 32'd0);
    check_order("t4_pre", '{0, 1, 2});
    repeat (5) @(posedge clk);
    #2;
    check("t4_resp_count", resp_count, 3);
    check("t4_idle", 32'(idle), 32'd1);
    check("t4_ready_still_off", 32'(req_ready), 32'd0);
    check("t4_no_new_grants", grant_log.size(), 3);
    enable = 1'b1;
    grant_log.delete();
    wait_drain("t4");
    check_order("t4_post", '{3, 0, 1, 2, 3});

    // Asynchronous reset with two operations in flight.
    sync();
    grant_log.delete();
    push_op(0, 16'd9, 16'd9, 1'b0, 32'd81);
    push_op(1, 16'd8, 16'd8, 1'b0, 32'd64);
    repeat (4) @(posedge clk);
    #2;
    check("t5_grants", grant_log.size(), 2);
    check("t5_ops_before", ops_issued, 32'd26);
    check("t5_ops_vs_hs", ops_issued, 32'(hs_total));
    #1;
    reset = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) opq[i].delete();
    #1;
    check_reset_values("t5_async");
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    check("t5_no_stale_resp", resp_count, 0);
    check("t5_ops_after", ops_issued, 32'd0);
    check("t5_idle", 32'(idle), 32'd1);

    // Mitchell-model multiplier attached.
    use_mitchell = 1'b1;
    sync();
    push_op(1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0000);
    wait_drain("t6a");
    check("t6_ops1", ops_issued, 32'd1);
    push_op(3, 16'd3, 16'd3, 1'b0, 32'd8);
    wait_drain("t6b");
    check("t6_ops2", ops_issued, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/app_mul_arbiter.md
Name: app_mul_arbiter

Overview:
- Shares one Mitchell approximate multiplier (mitchell_mult, 16x16 -> 32) between NUM_REQ requesters.
- Round-robin arbitration; at most one operation issued per cycle.
- Tracks the requester ID through the multiplier's fixed latency and returns each product to its owner.
- Sits between core-side multiply clients and the shared multiplier instance; includes a drain/enable control and an issue counter for debug.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MUL_LATENCY, 2, clock edges from mul_a/mul_b/mul_sign change to valid mul_product (0 = combinational multiplier).
- ID_W, $clog2(NUM_REQ), width of the requester ID.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low.
- enable  in  1  1 = accept new requests; 0 = stop granting and let the pipeline drain.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero.
- req_a  in  NUM_REQ x 16  multiplicand per requester.
- req_b  in  NUM_REQ x 16  multiplier per requester.
- req_sign  in  NUM_REQ  signed-operation flag per requester.
- mul_a  out  16  registered operand to the multiplier.
- mul_b  out  16  registered operand to the multiplier.
- mul_sign  out  1  registered sign flag to the multiplier.
- mul_product  in  32  multiplier result.
- resp_valid  out  NUM_REQ  one-hot, one-cycle pulse marking the response owner.
- resp_id  out  ID_W  ID of the response owner.
- resp_product  out  32  registered product.
- idle  out  1  1 = no operation in flight and no grant this cycle.
- ops_issued  out  32  count of handshakes since reset.

Behaviour:
- Reset values (asserted asynchronously): req_ready=0, mul_a=0, mul_b=0, mul_sign=0, resp_valid=0, resp_id=0, resp_product=0, ops_issued=0, idle=1, rr pointer=0, in-flight pipeline cleared.
- Grant (combinational):
  - Pick the first i with req_valid[i]=1, searching from the rr pointer upward with wrap.
  - req_ready[i]=1 only when enable=1.
  - No requester can hold off others indefinitely.
- Handshake: req_valid[i] & req_ready[i] at edge k.
  - At edge k: mul_a/mul_b/mul_sign <= req_a[i]/req_b[i]/req_sign[i]; rr pointer <= (i+1) mod NUM_REQ; ops_issued += 1 (wraps at 2^32).
  - The in-flight shift register (depth MUL_LATENCY+1) entry {valid, id=i} enters at stage 0.
- No grant in a cycle: mul_* hold their previous value and the rr pointer is unchanged.
- Response timing:
  - At edge k+MUL_LATENCY+1: resp_product <= mul_product; resp_id <= i; resp_valid <= one-hot(i) for exactly one cycle.
  - Back-to-back grants give back-to-back responses in issue order.
  - Throughput is 1 op/cycle.
- No response backpressure: requesters must accept resp_valid in the cycle it is asserted.
- Requester contract: a requester holds req_a/req_b/req_sign stable while req_valid=1 and ungranted. Deasserting req_valid without a grant is allowed.
- enable deasserted mid-operation:
  - No new grants from that cycle on.
  - In-flight operations complete normally; idle rises once the pipeline is empty.
- idle = ~(any in-flight valid) & ~(any req_ready).
- Same requester requesting again in the cycle after its grant: it is legal, and it wins only if no other requester is valid (pointer has moved past it).
- Reset mid-operation: all in-flight operations are discarded; no response is generated for them after reset release.
- Width rules:
  - Operands are passed through unmodified; sign only selects multiplier mode.
  - The product is not truncated.
  - ID_W is at least 1 even when NUM_REQ=2.

Decomposition:
- Shared package (app_mul_pkg):
  - typedef mul_operand_t (logic[15:0]);
  - typedef mul_product_t (logic[31:0]);
  - struct inflight_t {logic valid; logic[ID_W-1:0] id};
  - constant MITCHELL_LATENCY, which is the default for MUL_LATENCY.
- Sub-module rr_arbiter: parameter N; inputs request vector and pointer; outputs one-hot grant and encoded index. Combinational. Reused by other shared-unit arbiters.

Test Plan (NUM_REQ=4, MUL_LATENCY=2 with a behavioural exact-multiply model unless stated):
- Single request: req 2 valid, a=3, b=5 at edge 0 -> req_ready[2]=1 at edge 0; resp_valid=4'b0100, resp_id=2, resp_product=15 at edge 3; ops_issued=1; idle=1 at edge 4.
- All four requesters valid continuously from reset, distinct operands -> grants in order 0,1,2,3,0,...; responses one per cycle in the same order; each product matches its operands; no requester granted twice within 4 cycles.
- Sparse round-robin: pointer at 3; reqs 1 and 3 valid -> 3 granted, then 1, then 3 -> verifies wrap and fairness.
- enable=0 while 3 operations are in flight and reqs are pending -> req_ready=0; exactly 3 responses appear; idle=1 two cycles after the last response edge; enable=1 resumes granting from the saved pointer.
- Reset asserted (reset=0) one cycle after 2 grants, asynchronously between edges -> all outputs immediately at reset values; after release no stale resp_valid appears; ops_issued=0.
- Real mitchell_mult attached, sign=0, a=0xFFFF, b=0xFFFF -> resp_product equals the Mitchell model value after MITCHELL_LATENCY+1 edges; ops_issued increments by exactly 1 per handshake.
